// File: rtl/tx_clk_nco_pkg.sv
// Shared types and default parameters for the NCO clock generator.
// Lock FSM states and parameter defaults live here so the top and the bench agree.
package tx_clk_nco_pkg;

    localparam int DEF_NUM_CLKS = 2;
    localparam int DEF_ACC_W    = 24;
    localparam int DEF_LOCK_CNT = 256;

    typedef enum logic [1:0] {
        LOCK_IDLE   = 2'd0,
        LOCK_SETTLE = 2'd1,
        LOCK_LOCKED = 2'd2
    } lock_state_e;

endpackage

// File: rtl/tx_clk_nco_chan.sv
// One NCO channel: phase accumulator, carry-derived enable pulse and toggle output.
// A load replaces increment and phase and clears both outputs, overriding any wrap that edge.
module tx_clk_nco_chan
    import tx_clk_nco_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [ACC_W-1:0] load_incr_i,
    input  logic [ACC_W-1:0] load_acc_i,
    output logic             en_o,
    output logic             tgl_o,
    output logic             incr_nz_o
);

    logic [ACC_W-1:0] incr_q, incr_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             en_q, en_d;
    logic             tgl_q, tgl_d;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, incr_q};

    always_comb begin
        incr_d = incr_q;
        acc_d  = acc_q;
        en_d   = 1'b0;
        tgl_d  = tgl_q;
        if (load_i) begin
            incr_d = load_incr_i;
            acc_d  = load_acc_i;
            tgl_d  = 1'b0;
        end else if (incr_q != '0) begin
            acc_d = sum[ACC_W-1:0];
            en_d  = sum[ACC_W];
            tgl_d = tgl_q ^ sum[ACC_W];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            incr_q <= '0;
            acc_q  <= '0;
            en_q   <= 1'b0;
            tgl_q  <= 1'b0;
        end else begin
            incr_q <= incr_d;
            acc_q  <= acc_d;
            en_q   <= en_d;
            tgl_q  <= tgl_d;
        end
    end

    assign en_o      = en_q;
    assign tgl_o     = tgl_q;
    assign incr_nz_o = |incr_q;

endmodule

// File: rtl/tx_clk_nco_gen.sv
// Multi-channel NCO clock generator with a configuration port and a lock indicator.
// Define TX_CLK_NCO_PHASE_EN to load cfg_phase into the accumulator; otherwise it loads 0.
module tx_clk_nco_gen
    import tx_clk_nco_pkg::*;
#(
    parameter int NUM_CLKS = DEF_NUM_CLKS,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [2:0]          cfg_chan,
    input  logic [ACC_W-1:0]    cfg_incr,
    input  logic [ACC_W-1:0]    cfg_phase,
    output logic [NUM_CLKS-1:0] outclk_en,
    output logic [NUM_CLKS-1:0] outclk_tgl,
    output logic                locked,
    output logic [1:0]          lock_state_o
);

    localparam int                CNT_W    = $clog2(LOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CNT - 1);

    // Handshake: a config word is taken on any rising edge where cfg_valid && cfg_ready;
    // cfg_ready drops only during reset and the first cycle after it releases.
    logic ready_q;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) ready_q <= 1'b0;
        else     ready_q <= 1'b1;
    end

    assign cfg_ready = ready_q;

    logic                accept;
    logic                chan_ok;
    logic [NUM_CLKS-1:0] load_vec;
    logic [NUM_CLKS-1:0] incr_nz;
    logic                other_nz;
    logic                any_nz_after;
    logic [ACC_W-1:0]    load_acc;

    assign accept  = cfg_valid && ready_q;
    assign chan_ok = int'(cfg_chan) < NUM_CLKS;

`ifdef TX_CLK_NCO_PHASE_EN
    assign load_acc = cfg_phase;
`else
    logic unused_phase;
    assign unused_phase = ^cfg_phase;
    assign load_acc     = '0;
`endif

    always_comb begin
        load_vec = '0;
        other_nz = 1'b0;
        for (int i = 0; i < NUM_CLKS; i++) begin
            if (accept && int'(cfg_chan) == i) load_vec[i] = 1'b1;
            if (incr_nz[i] && int'(cfg_chan) != i) other_nz = 1'b1;
        end
    end

    // Whether any channel will still be running once the accepted word lands.
    assign any_nz_after = (cfg_incr != '0) || other_nz;

    for (genvar g = 0; g < NUM_CLKS; g++) begin : g_chan
        tx_clk_nco_chan #(.ACC_W(ACC_W)) u_chan (
            .clk_i      (refclk),
            .rst_i      (rst),
            .load_i     (load_vec[g]),
            .load_incr_i(cfg_incr),
            .load_acc_i (load_acc),
            .en_o       (outclk_en[g]),
            .tgl_o      (outclk_tgl[g]),
            .incr_nz_o  (incr_nz[g])
        );
    end

    lock_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             locked_q;

    // Any valid-channel accept restarts settling; the counter stops at its last value.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q  <= LOCK_IDLE;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else if (accept && chan_ok) begin
            cnt_q    <= '0;
            locked_q <= 1'b0;
            state_q  <= any_nz_after ? LOCK_SETTLE : LOCK_IDLE;
        end else begin
            case (state_q)
                LOCK_SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q  <= LOCK_LOCKED;
                        locked_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                LOCK_LOCKED: locked_q <= 1'b1;
                default: begin
                    state_q  <= LOCK_IDLE;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign locked       = locked_q;
    assign lock_state_o = state_q;

endmodule

// File: tb/tb_tx_clk_nco_gen.sv
// Directed bench for tx_clk_nco_gen with ACC_W=8, NUM_CLKS=2, LOCK_CNT=16.
module tb_tx_clk_nco_gen;

    localparam int NUM_CLKS = 2;
    localparam int ACC_W    = 8;
    localparam int LOCK_CNT = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic                refclk = 1'b0;
    logic                rst;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [2:0]          cfg_chan;
    logic [ACC_W-1:0]    cfg_incr;
    logic [ACC_W-1:0]    cfg_phase;
    logic [NUM_CLKS-1:0] outclk_en;
    logic [NUM_CLKS-1:0] outclk_tgl;
    logic                locked;
    logic [1:0]          lock_state_o;

    int n_vec = 0;
    int n_err = 0;

    tx_clk_nco_gen #(.NUM_CLKS(NUM_CLKS), .ACC_W(ACC_W), .LOCK_CNT(LOCK_CNT)) dut (
        .refclk      (refclk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_chan    (cfg_chan),
        .cfg_incr    (cfg_incr),
        .cfg_phase   (cfg_phase),
        .outclk_en   (outclk_en),
        .outclk_tgl  (outclk_tgl),
        .locked      (locked),
        .lock_state_o(lock_state_o)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic cfg_write(input logic [2:0] chan, input logic [ACC_W-1:0] incr,
                             input logic [ACC_W-1:0] phase);
        cfg_valid = 1'b1;
        cfg_chan  = chan;
        cfg_incr  = incr;
        cfg_phase = phase;
        @(posedge refclk);
        @(negedge refclk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        int first;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_incr  = '0;
        cfg_phase = '0;

        // Reset state
        @(negedge refclk);
        @(negedge refclk);
        check("rst_en",    32'(outclk_en),    32'd0);
        check("rst_tgl",   32'(outclk_tgl),   32'd0);
        check("rst_lock",  32'(locked),       32'd0);
        check("rst_ready", 32'(cfg_ready),    32'd0);
        check("rst_state", 32'(lock_state_o), 32'(ST_IDLE));
        rst = 1'b0;
        check("ready_first", 32'(cfg_ready), 32'd0);
        @(negedge refclk);
        check("ready_after", 32'(cfg_ready), 32'd1);

        // ch0 incr=0x40: pulse every 4, toggle period 8, locked 16 cycles after accept
        cfg_write(3'd0, 8'h40, 8'h00);
        check("settle_state", 32'(lock_state_o), 32'(ST_SETTLE));
        for (int k = 1; k <= 16; k++) begin
            @(negedge refclk);
            check("b_en0",  32'(outclk_en[0]),  32'((k % 4) == 0));
            check("b_tgl0", 32'(outclk_tgl[0]), 32'((k / 4) % 2));
            check("b_en1",  32'(outclk_en[1]),  32'd0);
            check("b_lock", 32'(locked),        32'(k >= 16));
        end
        check("locked_state", 32'(lock_state_o), 32'(ST_LOCKED));

        // Out-of-range channel while locked: consumed, nothing changes
        cfg_write(3'd7, 8'h10, 8'h00);
        check("c7_lock",  32'(locked),        32'd1);
        check("c7_state", 32'(lock_state_o),  32'(ST_LOCKED));
        check("c7_en0",   32'(outclk_en[0]),  32'd0);
        check("c7_tgl0",  32'(outclk_tgl[0]), 32'd0);
        check("c7_en1",   32'(outclk_en[1]),  32'd0);
        for (int k = 18; k <= 20; k++) begin
            @(negedge refclk);
            check("c_en0",  32'(outclk_en[0]),  32'((k % 4) == 0));
            check("c_tgl0", 32'(outclk_tgl[0]), 32'((k / 4) % 2));
            check("c_lock", 32'(locked),        32'd1);
            check("c_en1",  32'(outclk_en[1]),  32'd0);
        end

        // ch1 accept at r=0 (k=21), re-accept at r=10 -> locked at r=26
        cfg_write(3'd1, 8'h80, 8'h00);
        check("d_lock0", 32'(locked), 32'd0);
        for (int r = 1; r <= 9; r++) begin
            @(negedge refclk);
            check("d_lock", 32'(locked),       32'd0);
            check("d_en0",  32'(outclk_en[0]), 32'(((r + 21) % 4) == 0));
        end
        cfg_write(3'd1, 8'h80, 8'h00);
        check("d_reload_en1", 32'(outclk_en[1]), 32'd0);
        for (int r = 11; r <= 26; r++) begin
            @(negedge refclk);
            check("d2_lock", 32'(locked),        32'(r >= 26));
            check("d2_en1",  32'(outclk_en[1]),  32'(((r - 10) % 2) == 0));
            check("d2_tgl1", 32'(outclk_tgl[1]), 32'(((r - 10) / 2) % 2));
            check("d2_en0",  32'(outclk_en[0]),  32'(((r + 21) % 4) == 0));
        end

        // Zero both channels -> IDLE, outputs frozen
        cfg_write(3'd0, 8'h00, 8'h00);
        check("e_state_s", 32'(lock_state_o), 32'(ST_SETTLE));
        check("e_lock_s",  32'(locked),       32'd0);
        cfg_write(3'd1, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) begin
            check("e_state", 32'(lock_state_o), 32'(ST_IDLE));
            check("e_lock",  32'(locked),       32'd0);
            check("e_en",    32'(outclk_en),    32'd0);
            check("e_tgl",   32'(outclk_tgl),   32'd0);
            @(negedge refclk);
        end

        // Initial phase 0xC0: first pulse 1 cycle after accept with phase load, else 4
`ifdef TX_CLK_NCO_PHASE_EN
        first = 1;
`else
        first = 4;
`endif
        cfg_write(3'd0, 8'h40, 8'hC0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge refclk);
            check("f_en0", 32'(outclk_en[0]), 32'(k == first));
        end

        // Reload on the wrap edge: reload wins, pulse dropped
        cfg_write(3'd0, 8'h40, 8'h00);
        for (int k = 1; k <= 3; k++) begin
            @(negedge refclk);
            check("g_en0", 32'(outclk_en[0]), 32'd0);
        end
        cfg_write(3'd0, 8'h40, 8'h00);
        check("g_drop_en0",  32'(outclk_en[0]),  32'd0);
        check("g_drop_tgl0", 32'(outclk_tgl[0]), 32'd0);
        for (int k = 5; k <= 8; k++) begin
            @(negedge refclk);
            check("g2_en0",  32'(outclk_en[0]),  32'(k == 8));
            check("g2_tgl0", 32'(outclk_tgl[0]), 32'(k == 8));
        end

        // Async reset during SETTLE while a pulse is high
        check("h_state_pre", 32'(lock_state_o), 32'(ST_SETTLE));
        rst = 1'b1;
        #1;
        check("h_en",    32'(outclk_en),    32'd0);
        check("h_tgl",   32'(outclk_tgl),   32'd0);
        check("h_lock",  32'(locked),       32'd0);
        check("h_ready", 32'(cfg_ready),    32'd0);
        check("h_state", 32'(lock_state_o), 32'(ST_IDLE));
        @(negedge refclk);
        rst = 1'b0;
        check("h_ready_first", 32'(cfg_ready), 32'd0);
        @(negedge refclk);
        check("h_ready_after", 32'(cfg_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge refclk);
            check("h_quiet_en",  32'(outclk_en),    32'd0);
            check("h_quiet_tgl", 32'(outclk_tgl),   32'd0);
            check("h_quiet_st",  32'(lock_state_o), 32'(ST_IDLE));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tx_clk_nco_gen.md
TX_CLK_NCO_GEN -- requirements
Module: tx_clk_nco_gen

Interface
REQ-001 SHALL have parameter NUM_CLKS, default 2, number of generated clock channels (1..8).
REQ-002 SHALL have parameter ACC_W, default 24, phase-accumulator width in bits (8..32).
REQ-003 SHALL have parameter LOCK_CNT, default 256, settle cycles before locked asserts (>=2).
REQ-004 SHALL have port refclk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cfg_valid  input  1  configuration request.
REQ-007 SHALL have port cfg_ready  output  1  configuration accept.
REQ-008 SHALL have port cfg_chan  input  3  target channel index.
REQ-009 SHALL have port cfg_incr  input  ACC_W  frequency word; fout = f_refclk*incr/2^ACC_W.
REQ-010 SHALL have port cfg_phase  input  ACC_W  initial accumulator value.
REQ-011 SHALL have port outclk_en  output  NUM_CLKS  one-cycle enable pulse per accumulator wrap.
REQ-012 SHALL have port outclk_tgl  output  NUM_CLKS  square wave, toggles on each wrap.
REQ-013 SHALL have port locked  output  1  all configured channels settled.

Function
REQ-014 Per channel: each edge, {carry,acc} <= acc + incr (ACC_W+1 bits); outclk_en <= carry; outclk_tgl ^= carry; same edge, no further latency.
REQ-015 incr = 0 SHALL freeze the channel: acc holds, outclk_en 0, outclk_tgl holds.
REQ-016 Config accepted on edge with cfg_valid && cfg_ready; cfg_ready SHALL be 1 in every cycle except the first cycle after rst deassertion.
REQ-017 On accept with cfg_chan < NUM_CLKS: incr <= cfg_incr, acc <= cfg_phase, outclk_en <= 0, outclk_tgl <= 0 for that channel; new incr used from the following edge; other channels unaffected.
REQ-018 Accept with cfg_chan >= NUM_CLKS SHALL be consumed with no state change (locked unaffected).
REQ-019 Accept coinciding with a wrap on the targeted channel: reload wins, pulse dropped.
REQ-020 Lock FSM states IDLE, SETTLE, LOCKED; locked = 1 only in LOCKED.
REQ-021 IDLE -> SETTLE on valid-channel accept with nonzero cfg_incr; counter cleared.
REQ-022 SETTLE -> LOCKED after counter reaches LOCK_CNT-1 (locked high LOCK_CNT cycles after accept edge).
REQ-023 Any valid-channel accept in SETTLE or LOCKED -> SETTLE, counter cleared (restart, not extend).
REQ-024 If every channel incr = 0 after an accept -> IDLE.
REQ-025 Lock counter SHALL saturate, never wrap.

Reset
REQ-026 rst asserted SHALL clear asynchronously: all acc, incr, outclk_en, outclk_tgl to 0; locked 0; cfg_ready 0; FSM IDLE.
REQ-027 rst mid-SETTLE or mid-configuration SHALL discard pending state; no pulse after deassertion until reconfigured.

Configuration
REQ-028 Macro TX_CLK_NCO_PHASE_EN defined: cfg_phase loaded per REQ-017.
REQ-029 Macro undefined: cfg_phase ignored, acc loaded with 0 on accept; port remains present.

Structure
REQ-030 Package tx_clk_nco_pkg SHALL hold the lock-FSM state enum and default parameter constants.
REQ-031 Per-channel accumulator/pulse/toggle logic SHALL be sub-module tx_clk_nco_chan, instantiated NUM_CLKS times by generate.

Verification
REQ-032 ACC_W=8, incr=0x40 ch0 -> outclk_en pulse every 4 cycles, outclk_tgl period 8 cycles.
REQ-033 PHASE_EN, ACC_W=8, incr=0x40, phase=0xC0 -> first pulse one cycle after accept edge; without macro, first pulse four cycles after.
REQ-034 LOCK_CNT=16: accept at cycle 0 -> locked rises cycle 16; re-accept at cycle 10 -> locked rises cycle 26.
REQ-035 cfg_chan=7 with NUM_CLKS=2 in LOCKED -> accepted, locked stays 1, outputs unchanged.
REQ-036 incr=0 written to only active channel -> FSM IDLE, locked 0, outclk_tgl frozen.
REQ-037 rst pulse during SETTLE -> all outputs 0 immediately; cfg_ready 0 one cycle after deassertion, then 1.
